// File: rtl/i_decode.sv
// RV32I decode stage: IF/ID capture, field/immediate decode, register file
// with write-back bypass, and the ID/EX register feeding execute.
module i_decode #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic        id_reg_write,
  output logic        id_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_instr;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      dec_opcode;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd_raw;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            dec_legal;
  logic            dec_wr_class;
  logic            dec_no_rd;
  logic            dec_reg_write;
  logic            wb_hit;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // IF/ID register: flush squashes to a NOP bubble, stall holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP;
    end else if (flush) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP;
    end else if (!stall) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= if_pc;
      ifid_instr <= if_instr;
    end
  end

  // Register file write port; x0 is never written and reads as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign dec_opcode = ifid_instr[6:0];
  assign dec_rs1    = ifid_instr[19:15];
  assign dec_rs2    = ifid_instr[24:20];
  assign dec_rd_raw = ifid_instr[11:7];
  assign wb_hit     = wb_en && (wb_rd != 5'd0);

  // Opcode classification and immediate formation
  always_comb begin
    dec_imm      = '0;
    dec_legal    = 1'b1;
    dec_wr_class = 1'b0;
    dec_no_rd    = 1'b0;
    case (dec_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_imm      = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        dec_wr_class = 1'b1;
      end
      OP_SYSTEM, OP_FENCE: begin
        dec_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
      end
      OP_STORE: begin
        dec_imm   = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
        dec_no_rd = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm   = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                     ifid_instr[30:25], ifid_instr[11:8], 1'b0};
        dec_no_rd = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm      = {ifid_instr[31:12], 12'h000};
        dec_wr_class = 1'b1;
      end
      OP_JAL: begin
        dec_imm      = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                        ifid_instr[20], ifid_instr[30:21], 1'b0};
        dec_wr_class = 1'b1;
      end
      OP_OP: begin
        dec_wr_class = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign dec_rd        = dec_no_rd ? 5'd0 : dec_rd_raw;
  assign dec_reg_write = ifid_valid && dec_legal && dec_wr_class && (dec_rd != 5'd0);

  // Operand read with same-cycle write-back bypass
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (dec_rs1 != 5'd0) rs1_val = (wb_hit && (wb_rd == dec_rs1)) ? wb_data : regs[dec_rs1];
    if (dec_rs2 != 5'd0) rs2_val = (wb_hit && (wb_rd == dec_rs2)) ? wb_data : regs[dec_rs2];
  end

  // ID/EX register: stall or flush inject an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_opcode    <= '0;
      id_funct3    <= '0;
      id_funct7b5  <= 1'b0;
      id_reg_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (flush || stall) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_opcode    <= '0;
      id_funct3    <= '0;
      id_funct7b5  <= 1'b0;
      id_reg_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else begin
      id_valid     <= ifid_valid;
      id_pc        <= ifid_pc;
      id_rs1_data  <= rs1_val;
      id_rs2_data  <= rs2_val;
      id_imm       <= dec_imm;
      id_rs1       <= dec_rs1;
      id_rs2       <= dec_rs2;
      id_rd        <= dec_rd;
      id_opcode    <= dec_opcode;
      id_funct3    <= ifid_instr[14:12];
      id_funct7b5  <= ifid_instr[30];
      id_reg_write <= dec_reg_write;
      id_illegal   <= !dec_legal;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: directed vectors push hand-computed ID/EX
// records tagged with the edge they must appear after; a monitor compares.
module tb_i_decode;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        rw;
    logic        ill;
  } rec_t;

  typedef struct {
    int   cyc;
    int   tag;
    rec_t r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr;
  logic        stall, flush, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_write, id_illegal;

  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;
  int   tagn   = 0;
  exp_t q[$];
  rec_t act;

  i_decode dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  assign act = '{valid: id_valid, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data,
                 imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_opcode,
                 f3: id_funct3, f7: id_funct7b5, rw: id_reg_write, ill: id_illegal};

  function automatic rec_t mk(logic v, logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [6:0] op, logic [2:0] f3,
                              logic f7, logic rw, logic ill);
    return '{valid: v, pc: pc, rs1d: a, rs2d: b, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
             op: op, f3: f3, f7: f7, rw: rw, ill: ill};
  endfunction

  task automatic show(string name, rec_t got, rec_t exp);
    $display("FAIL %s got v=%b pc=%h a=%h b=%h imm=%h rs1=%0d rs2=%0d rd=%0d op=%h f3=%0d f7=%b rw=%b ill=%b | exp v=%b pc=%h a=%h b=%h imm=%h rs1=%0d rs2=%0d rd=%0d op=%h f3=%0d f7=%b rw=%b ill=%b",
             name, got.valid, got.pc, got.rs1d, got.rs2d, got.imm, got.rs1, got.rs2, got.rd,
             got.op, got.f3, got.f7, got.rw, got.ill, exp.valid, exp.pc, exp.rs1d, exp.rs2d,
             exp.imm, exp.rs1, exp.rs2, exp.rd, exp.op, exp.f3, exp.f7, exp.rw, exp.ill);
  endtask

  // Expected record due after edge (current edge + off)
  task automatic push(int off, rec_t r);
    exp_t e;
    e.cyc = ecount + off;
    e.tag = tagn;
    e.r   = r;
    tagn++;
    q.push_back(e);
  endtask

  task automatic drive(logic [31:0] pc, logic [31:0] ins, logic st, logic fl,
                       logic we, logic [4:0] wrd, logic [31:0] wd);
    if_pc = pc; if_instr = ins; stall = st; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    @(negedge clk);
  endtask

  always @(posedge clk) ecount++;

  // Monitor: compare every record that falls due after the latest edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= ecount) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < ecount) begin
        errors++;
        $display("FAIL missed_vec%0d due edge %0d now %0d", e.tag, e.cyc, ecount);
      end else if (act !== e.r) begin
        errors++;
        show($sformatf("vec%0d", e.tag), act, e.r);
      end
    end
  end

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LUI   = 32'h1234_52B7;
  localparam logic [31:0] ADD33 = 32'h0031_8233;
  localparam logic [31:0] ADD00 = 32'h0000_0233;
  localparam logic [31:0] DB    = 32'hDEAD_BEEF;

  initial begin
    rst = 1'b0;
    if_pc = '0; if_instr = '0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #3;
    checks++;
    if (act !== rec_t'(0)) begin errors++; show("reset_init", act, rec_t'(0)); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Basic decode and immediate formats; x2 written alongside addi
    push(2, mk(1, 32'h00, 0, 0, 32'h5, 0, 5, 1, 7'h13, 0, 0, 1, 0));
    drive(32'h00, ADDI, 0, 0, 1, 5'd2, 32'h1111_2222);
    push(2, mk(1, 32'h04, 0, 32'h1111_2222, 32'h8, 1, 2, 0, 7'h23, 2, 0, 0, 0));
    drive(32'h04, 32'h0020_A423, 0, 0, 0, 0, 0);
    push(2, mk(1, 32'h08, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 7'h63, 0, 1, 0, 0));
    drive(32'h08, 32'hFE00_0EE3, 0, 0, 0, 0, 0);
    push(2, mk(1, 32'h0C, 0, 0, 32'h1234_5000, 8, 3, 5, 7'h37, 5, 0, 1, 0));
    drive(32'h0C, LUI, 0, 0, 0, 0, 0);
    push(2, mk(1, 32'h10, 0, 0, 32'h0000_0800, 0, 1, 1, 7'h6F, 0, 0, 1, 0));
    drive(32'h10, 32'h0010_00EF, 0, 0, 0, 0, 0);

    // Bypass of x3 while add sits in IF/ID, then x0 write attempts
    push(2, mk(1, 32'h14, DB, DB, 0, 3, 3, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h14, ADD33, 0, 0, 0, 0, 0);
    push(2, mk(1, 32'h18, 0, 0, 0, 0, 0, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h18, ADD00, 0, 0, 1, 5'd3, DB);
    push(2, mk(1, 32'h1C, 0, 0, 0, 0, 0, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h1C, ADD00, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    push(2, mk(1, 32'h20, DB, DB, 0, 3, 3, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h20, ADD33, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    push(2, mk(1, 32'h24, 0, 0, 0, 0, 0, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h24, ADD00, 0, 0, 0, 0, 0);

    // Two-cycle stall with addi held; x5 written during the stall
    drive(32'h40, ADDI, 0, 0, 0, 0, 0);
    push(1, rec_t'(0));
    drive(32'h44, LUI, 1, 0, 1, 5'd5, 32'h55);
    push(1, rec_t'(0));
    drive(32'h44, LUI, 1, 0, 0, 0, 0);
    push(1, mk(1, 32'h40, 0, 32'h55, 32'h5, 0, 5, 1, 7'h13, 0, 0, 1, 0));
    push(2, mk(1, 32'h44, 0, DB, 32'h1234_5000, 8, 3, 5, 7'h37, 5, 0, 1, 0));
    drive(32'h44, LUI, 0, 0, 0, 0, 0);

    // Flush together with stall; the NOP left in IF/ID decodes with valid=0
    push(2, mk(1, 32'h80, DB, DB, 0, 3, 3, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h80, ADD33, 0, 0, 0, 0, 0);
    drive(32'h84, 32'h0010_00EF, 0, 0, 0, 0, 0);
    push(1, rec_t'(0));
    drive(32'h88, ADDI, 1, 1, 0, 0, 0);
    push(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 7'h13, 0, 0, 0, 0));
    push(2, mk(1, 32'h8C, 0, 32'h55, 32'h5, 0, 5, 1, 7'h13, 0, 0, 1, 0));
    drive(32'h8C, ADDI, 0, 0, 0, 0, 0);

    // Illegal opcode, with x1 written so reset clearing is observable
    push(2, mk(1, 32'hC0, 0, 0, 0, 31, 31, 31, 7'h7F, 7, 1, 0, 1));
    drive(32'hC0, 32'hFFFF_FFFF, 0, 0, 1, 5'd1, 32'h1111);
    drive(32'hC4, ADDI, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-stream, between clock edges
    #2 rst = 1'b0;
    #1;
    checks++;
    if (act !== rec_t'(0)) begin errors++; show("reset_async", act, rec_t'(0)); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    push(2, mk(1, 32'h100, 0, 0, 0, 1, 1, 4, 7'h33, 0, 0, 1, 0));
    drive(32'h100, 32'h0010_8233, 0, 0, 0, 0, 0);
    drive(32'h104, ADDI, 0, 0, 0, 0, 0);
    drive(32'h108, ADDI, 0, 0, 0, 0, 0);
    drive(32'h10C, ADDI, 0, 0, 0, 0, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
